// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the 32x32 Sobel operator: loads a frame, sweeps every address, streams tagged results.
// Build macro SOBEL_MAG_EN adds the saturating res_mag output.
`timescale 1ns/1ps
module sobel_frame_ctrl #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 12,
  parameter int G_W    = 4,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [PIX_W-1:0]  mem_wr_data,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_sobel_en,
  input  logic [G_W-1:0]    mem_gx,
  input  logic [G_W-1:0]    mem_gy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_addr,
  output logic [G_W-1:0]    res_gx,
  output logic [G_W-1:0]    res_gy
`ifdef SOBEL_MAG_EN
  ,
  output logic [G_W-1:0]    res_mag
`endif
);

  localparam int N     = IMG_W * IMG_H;
  localparam int DEPTH = LAT + 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + LAT + 2) + 1;
  localparam int EW    = ADDR_W + 2 * G_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] ld_cnt_r;
  logic [ADDR_W-1:0] rd_cnt_r;
  logic              done_r;
  logic [LAT-1:0]    tag_v_r;
  logic [ADDR_W-1:0] tag_a_r [LAT];
  logic [EW-1:0]     fifo_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;

  logic              accept_s;
  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  logic [CW-1:0]     inflight_s;
  logic [CW-1:0]     need_s;
  logic [CW-1:0]     allow_s;
  logic [EW-1:0]     head_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) ptr_next = '0;
    else                     ptr_next = p + PW'(1);
  endfunction

  // Handshakes and issue credit: an issue must still fit if no further pops arrive.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < LAT; i++) inflight_s = inflight_s + CW'(tag_v_r[i]);
    accept_s = (state_r == LOAD) && pix_valid && !abort;
    pop_s    = (count_r != '0) && res_ready;
    push_s   = tag_v_r[LAT-1];
    need_s   = count_r + inflight_s + CW'(1);
    allow_s  = CW'(DEPTH) + CW'(pop_s);
    issue_s  = (state_r == RUN) && !abort && (need_s <= allow_s);
    head_s   = fifo_r[rd_ptr_r];
  end

  assign busy         = (state_r != IDLE);
  assign pix_ready    = (state_r == LOAD);
  assign mem_wr_en    = accept_s;
  assign mem_wr_addr  = accept_s ? ld_cnt_r : '0;
  assign mem_wr_data  = accept_s ? pix_data : '0;
  assign mem_rd_addr  = rd_cnt_r;
  assign mem_sobel_en = issue_s;
  assign res_valid    = (count_r != '0);
  assign done         = done_r;
  assign {res_addr, res_gx, res_gy} = res_valid ? head_s : '0;

  // Frame sequencer and load/read counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      ld_cnt_r <= '0;
      rd_cnt_r <= '0;
      done_r   <= 1'b0;
    end else if (abort) begin
      state_r  <= IDLE;
      ld_cnt_r <= '0;
      rd_cnt_r <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r  <= LOAD;
            ld_cnt_r <= '0;
            rd_cnt_r <= '0;
          end
        end
        LOAD: begin
          if (accept_s) begin
            if (ld_cnt_r == LAST) state_r  <= RUN;
            else                  ld_cnt_r <= ld_cnt_r + ADDR_W'(1);
          end
        end
        RUN: begin
          if (issue_s) begin
            if (rd_cnt_r == LAST) state_r  <= DRAIN;
            else                  rd_cnt_r <= rd_cnt_r + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // the final pop with nothing left in flight closes the frame
          if ((inflight_s == '0) && pop_s && (count_r == CW'(1))) begin
            done_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Address tag pipe, aligned with the operator latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_r <= '0;
      for (int i = 0; i < LAT; i++) tag_a_r[i] <= '0;
    end else if (abort) begin
      tag_v_r <= '0;
    end else begin
      tag_v_r[0] <= issue_s;
      tag_a_r[0] <= rd_cnt_r;
      for (int i = 1; i < LAT; i++) begin
        tag_v_r[i] <= tag_v_r[i-1];
        tag_a_r[i] <= tag_a_r[i-1];
      end
    end
  end

  // First-word-fall-through result FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_r[i] <= '0;
    end else if (abort) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= {tag_a_r[LAT-1], mem_gx, mem_gy};
        wr_ptr_r         <= ptr_next(wr_ptr_r);
      end
      if (pop_s) rd_ptr_r <= ptr_next(rd_ptr_r);
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

`ifdef SOBEL_MAG_EN
  function automatic logic [G_W-1:0] sat_add(input logic [G_W-1:0] a, input logic [G_W-1:0] b);
    logic [G_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[G_W]) sat_add = '1;
    else        sat_add = s[G_W-1:0];
  endfunction

  assign res_mag = sat_add(res_gx, res_gy);
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Randomized bench for sobel_frame_ctrl with a stand-in operator and a per-address result reference.
`timescale 1ns/1ps
module tb_sobel_frame_ctrl;

  localparam int N     = 1024;
  localparam int AW    = 10;
  localparam int PW    = 12;
  localparam int GW    = 4;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst, start, abort, busy, done;
  logic          pix_valid, pix_ready;
  logic [PW-1:0] pix_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [PW-1:0] mem_wr_data;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_sobel_en;
  logic [GW-1:0] mem_gx, mem_gy;
  logic          res_valid, res_ready;
  logic [AW-1:0] res_addr;
  logic [GW-1:0] res_gx, res_gy;
`ifdef SOBEL_MAG_EN
  logic [GW-1:0] res_mag;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sobel_frame_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_addr(mem_rd_addr), .mem_sobel_en(mem_sobel_en),
    .mem_gx(mem_gx), .mem_gy(mem_gy),
    .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr),
    .res_gx(res_gx), .res_gy(res_gy)
`ifdef SOBEL_MAG_EN
    , .res_mag(res_mag)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  logic [PW-1:0] ref_img [N];
  logic [PW-1:0] img_mem [N];
  bit            inject = 1'b0;

  function automatic int px(input bit from_ref, input int a);
    if (from_ref) return int'(ref_img[a]);
    return int'(img_mem[a]);
  endfunction

  // Stand-in gradient: clipped neighbour difference, zero on the border.
  function automatic logic [GW-1:0] grad(input bit from_ref, input int a, input bit vert);
    int x, y, d;
    x = a % 32;
    y = a / 32;
    if (inject) return vert ? 4'd12 : 4'd9;
    if (x == 0 || x == 31 || y == 0 || y == 31) return 4'd0;
    if (vert) d = px(from_ref, a + 32) - px(from_ref, a - 32);
    else      d = px(from_ref, a + 1) - px(from_ref, a - 1);
    if (d < 0) d = -d;
    if (d > 15) d = 15;
    return GW'(d);
  endfunction

  // Operator memory and registered gradient outputs (LAT = 1)
  always @(posedge clk) begin
    if (mem_wr_en) img_mem[mem_wr_addr] <= mem_wr_data;
    if (mem_sobel_en) begin
      mem_gx <= grad(1'b0, int'(mem_rd_addr), 1'b0);
      mem_gy <= grad(1'b0, int'(mem_rd_addr), 1'b1);
    end else begin
      mem_gx <= 4'd0;
      mem_gy <= 4'd0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_idx, res_idx, issued, hs_n, done_cnt, first_hs, last_hs, ready_mode;
  int a_m, gx_e, gy_e, mag_e;

  // Monitor: writes, results, issue credit and done timing
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_en) begin
        check_eq("wr_addr", mem_wr_addr, wr_idx);
        check_eq("wr_data", mem_wr_data, ref_img[wr_idx % N]);
        check_eq("wr_in_load", pix_ready, 1);
        wr_idx++;
      end
      if (res_valid && res_ready) begin
        a_m  = (res_idx < N) ? res_idx : N - 1;
        gx_e = grad(1'b1, a_m, 1'b0);
        gy_e = grad(1'b1, a_m, 1'b1);
        check_eq("res_addr", res_addr, res_idx);
        check_eq("res_gx", res_gx, gx_e);
        check_eq("res_gy", res_gy, gy_e);
`ifdef SOBEL_MAG_EN
        mag_e = (gx_e + gy_e > 15) ? 15 : gx_e + gy_e;
        check_eq("res_mag", res_mag, mag_e);
`endif
        if (res_idx == 0) first_hs = cyc;
        last_hs = cyc;
        res_idx++;
        hs_n++;
      end
      if (mem_sobel_en) begin
        issued++;
        check_eq("credit", (issued - hs_n) <= DEPTH, 1);
        check_eq("en_not_load", pix_ready, 0);
      end
      if (done) begin
        done_cnt++;
        check_eq("done_count", res_idx, N);
        check_eq("done_lat", cyc - last_hs, 1);
        if (ready_mode == 0) check_eq("throughput", last_hs - first_hs, N - 1);
      end
    end
  end

  int rcnt = 0;
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
      rcnt++;
    end
  end

  task automatic fill_img(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       ref_img[i] = PW'($urandom_range(0, 15));
        1:       ref_img[i] = 12'd5;
        default: ref_img[i] = PW'(i);
      endcase
    end
  endtask

  task automatic begin_frame();
    wr_idx = 0; res_idx = 0; issued = 0; hs_n = 0; done_cnt = 0; first_hs = 0; last_hs = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_load", busy, 1);
    check_eq("ready_load", pix_ready, 1);
  endtask

  task automatic feed();
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < N && guard < 8000) begin
      pix_data  = ref_img[i];
      pix_valid = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = pix_valid && pix_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    pix_valid = 1'b0;
    check_eq("feed_complete", i, N);
  endtask

  task automatic wait_done();
    int c = 0;
    @(negedge clk);
    while (!done && c < 6000) begin
      @(negedge clk);
      c++;
    end
    check_eq("done_seen", done, 1);
    @(posedge clk); #1;
    check_eq("done_pulse", done, 0);
    check_eq("idle_after", busy, 0);
    check_eq("one_done", done_cnt, 1);
  endtask

  task automatic run_frame(input int kind, input int rmode, input bit inj);
    fill_img(kind);
    inject     = inj;
    ready_mode = rmode;
    begin_frame();
    feed();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    int c;
    int d;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_data = '0; ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pix_ready", pix_ready, 0);
    check_eq("rst_sobel_en", mem_sobel_en, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_rd_addr", mem_rd_addr, 0);
    rst = 1'b0;

    pix_valid = 1'b1; pix_data = 12'd7;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_wr_en", mem_wr_en, 0);
    check_eq("idle_pix_ready", pix_ready, 0);
    pix_valid = 1'b0;

    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check_eq("abort_beats_start", busy, 0);

    run_frame(2, 0, 1'b0);
    run_frame(0, 1, 1'b0);
    run_frame(1, 2, 1'b0);
    run_frame(0, 0, 1'b1);
    inject = 1'b0;

    fill_img(0);
    ready_mode = 2;
    begin_frame();
    feed();
    c = 0;
    while (mem_rd_addr != 10'd500 && c < 4000) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq("reach_500", mem_rd_addr, 500);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_res_valid", res_valid, 0);
    check_eq("abort_sobel_en", mem_sobel_en, 0);
    d = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) d++;
    end
    check_eq("abort_no_done", d, 0);
    run_frame(0, 0, 1'b0);

    fill_img(0);
    ready_mode = 1;
    begin_frame();
    feed();
    repeat (100) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_res_valid", res_valid, 0);
    check_eq("arst_sobel_en", mem_sobel_en, 0);
    check_eq("arst_rd_addr", mem_rd_addr, 0);
    check_eq("arst_done", done, 0);
    #1;
    rst = 1'b0;
    run_frame(0, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
